// File: rtl/sram_pkg.sv
// sram_pkg: shared widths and FSM state encoding for the SRAM controller
package sram_pkg;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WAIT_CNT_W = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LO = 2'd1;
    localparam state_t HI = 2'd2;
    localparam state_t DONE = 2'd3;
endpackage

// File: rtl/sram_if.sv
// sram_if: CPU-side load/store handshake of the SRAM controller
interface sram_if;
    logic wr_en, rd_en, ready;
    logic [31:0] address, write_data, read_data;
    modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
    modport slave (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: per-phase wait counter that wraps at terminal count SRAM_WAIT-1
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int SRAM_WAIT = 2
) (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic en,
    output logic tc
);
    logic [WAIT_CNT_W-1:0] cnt;
    assign tc = cnt == WAIT_CNT_W'(SRAM_WAIT - 1);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit CPU load/store over a 16-bit async SRAM in two half-word phases; SRAM_POSTED_WRITE_EN adds a one-entry posted write buffer
module sram_controller
    import sram_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input logic clk,
    input logic rst,
    sram_if.slave bus,
    inout wire [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic SRAM_WE_N,
    output logic SRAM_UB_N,
    output logic SRAM_LB_N,
    output logic SRAM_CE_N,
    output logic SRAM_OE_N
);
    state_t state;
    logic tc, req, busy, last, op_wr, bg, idle_ok;
    logic [31:0] op_addr, op_data, off, rd_q;
    logic [SRAM_DATA_W-1:0] rd_lo;
    logic unused_off;
    assign req = bus.wr_en | bus.rd_en;
    assign busy = state == LO || state == HI;
    assign last = busy && tc;
`ifdef SRAM_POSTED_WRITE_EN
    logic [31:0] pw_addr, pw_data;
    always_ff @(posedge clk)
        if (rst) bg <= 1'b0;
        else if (state == IDLE && bus.wr_en) begin
            bg <= 1'b1;
            pw_addr <= bus.address;
            pw_data <= bus.write_data;
        end else if (state == HI && tc) bg <= 1'b0;
    assign idle_ok = bus.wr_en;
    assign op_wr = bg | bus.wr_en;
    assign op_addr = bg ? pw_addr : bus.address;
    assign op_data = bg ? pw_data : bus.write_data;
`else
    assign bg = 1'b0;
    assign idle_ok = 1'b0;
    assign op_wr = bus.wr_en;
    assign op_addr = bus.address;
    assign op_data = bus.write_data;
`endif
    sram_wait_counter #(.SRAM_WAIT(SRAM_WAIT)) u_wait (
        .clk(clk),
        .rst(rst),
        .clr(!busy),
        .en(busy),
        .tc(tc)
    );
    assign off = op_addr - BASE_ADDR;
    assign unused_off = &{1'b0, off[31:19], off[1:0]};
    assign SRAM_ADDR = {off[18:2], state == HI};
    assign SRAM_WE_N = ~(op_wr & last);
    assign SRAM_DQ = (op_wr && busy) ? (state == HI ? op_data[31:16] : op_data[15:0]) : {SRAM_DATA_W{1'bz}};
    assign {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N} = 4'b0000;
    assign bus.read_data = rd_q;
    assign bus.ready = (state == IDLE) ? (!req || idle_ok) : (state == DONE || (bg && !req));
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state == IDLE ? (req ? LO : IDLE)
                    : state == LO ? (tc ? HI : LO)
                    : state == HI ? (tc ? (bg ? IDLE : DONE) : HI)
                    : IDLE;
    always_ff @(posedge clk)
        if (rst) begin
            rd_lo <= '0;
            rd_q <= '0;
        end else if (last && !op_wr) begin
            if (state == LO) rd_lo <= SRAM_DQ;
            else rd_q <= {SRAM_DQ, rd_lo};
        end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table, hand-sequence and random checks of sram_controller against a transaction-level SRAM model
module tb_sram_controller;
    localparam int W = 2;
    localparam int LAT = 2 * W + 1;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    typedef struct packed {
        logic wr;
        logic rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic chk;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_if bus();
    wire [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic we_n, ub_n, lb_n, ce_n, oe_n;
    logic [15:0] sram_mem [0:(1<<18)-1];
    logic tb_oe;
    int vecs = 0;
    int bad = 0;
    int cyc = 0;
    int free_cyc = 0;

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
    end
    assign tb_oe = bus.rd_en & ~bus.wr_en & we_n;
    assign sram_dq = tb_oe ? sram_mem[sram_addr] : 16'bz;
    always @(posedge clk) cyc <= cyc + 1;

    sram_controller #(.SRAM_WAIT(W), .BASE_ADDR(32'd1024)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 4951 + 165);
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) sram_mem[i] = pat(i);
        sram_mem[2] = 16'hBEEF;
        sram_mem[3] = 16'hDEAD;
        forever begin
            @(posedge clk);
            if (!we_n) sram_mem[sram_addr] <= sram_dq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_lat(input logic wr, input int t, output int el);
        int s;
        s = (t > free_cyc) ? t : free_cyc;
        if (POSTED && wr) begin
            free_cyc = s + LAT;
            el = s - t;
        end else begin
            free_cyc = s + LAT + 1;
            el = s + LAT - t;
        end
    endtask

    task automatic do_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q, output int lat);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.address = a;
        bus.write_data = d;
        lat = 0;
        @(negedge clk);
        while (!bus.ready && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        q = bus.read_data;
        sync;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        vec_t tbl [9];
        logic [31:0] q, d, last_q;
        logic [31:0] ref_w [8];
        logic wr;
        int lat, el, idx;
        tbl = '{
            '{1'b1, 1'b0, 32'd1024,       32'h12345678, 32'h0,        1'b0},
            '{1'b0, 1'b1, 32'd1024,       32'h0,        32'h12345678, 1'b1},
            '{1'b0, 1'b1, 32'd1028,       32'h0,        32'hDEADBEEF, 1'b1},
            '{1'b1, 1'b0, 32'd2048,       32'hCAFEF00D, 32'h0,        1'b0},
            '{1'b0, 1'b1, 32'd2048,       32'h0,        32'hCAFEF00D, 1'b1},
            '{1'b1, 1'b1, 32'd1032,       32'h0BADC0DE, 32'h0,        1'b0},
            '{1'b0, 1'b1, 32'd1032,       32'h0,        32'h0BADC0DE, 1'b1},
            '{1'b1, 1'b0, 32'h000803FC,   32'hA5A55A5A, 32'h0,        1'b0},
            '{1'b0, 1'b1, 32'h000803FC,   32'h0,        32'hA5A55A5A, 1'b1}
        };
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.address = 32'd0;
        bus.write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_dq_z", 32'(sram_dq), 32'h0000FFFF);
        check("rst_rdata", bus.read_data, 32'd0);
        check("tied_low", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
        sync;

        bus.rd_en = 1'b1;
        bus.address = 32'd1028;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            check($sformatf("rd_ready_c%0d", c), 32'(bus.ready), 32'(c == LAT));
            if (c >= 1 && c <= 2 * W) check($sformatf("rd_addr_c%0d", c), 32'(sram_addr), (c <= W) ? 32'd2 : 32'd3);
        end
        check("rd_data", bus.read_data, 32'hDEADBEEF);
        sync;
        bus.rd_en = 1'b0;

        bus.wr_en = 1'b1;
        bus.address = 32'd1024;
        bus.write_data = 32'h12345678;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 0 || !POSTED) check($sformatf("wr_ready_c%0d", c), 32'(bus.ready), POSTED ? 32'd1 : 32'(c == LAT));
            if (c >= 1 && c <= 2 * W) begin
                check($sformatf("wr_we_n_c%0d", c), 32'(we_n), (c == W || c == 2 * W) ? 32'd0 : 32'd1);
                if (!we_n) begin
                    check($sformatf("wr_addr_c%0d", c), 32'(sram_addr), (c <= W) ? 32'd0 : 32'd1);
                    check($sformatf("wr_dq_c%0d", c), 32'(sram_dq), (c <= W) ? 32'h5678 : 32'h1234);
                end
            end
            if (POSTED && c == 0) begin
                sync;
                bus.wr_en = 1'b0;
            end
        end
        check("wr_hold_rdata", bus.read_data, 32'hDEADBEEF);
        sync;
        bus.wr_en = 1'b0;

        bus.rd_en = 1'b1;
        bus.address = 32'd1028;
        repeat (W + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.rd_en = 1'b0;
        sync;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_we_n", 32'(we_n), 32'd1);
        check("mid_rst_dq_z", 32'(sram_dq), 32'h0000FFFF);
        check("mid_rst_rdata", bus.read_data, 32'd0);
        sync;

        bus.address = 32'd1028;
        bus.write_data = 32'h12345678;
        repeat (20) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.ready), 32'd1);
            check("idle_we_n", 32'(we_n), 32'd1);
            check("idle_dq_z", 32'(sram_dq), 32'h0000FFFF);
        end
        sync;

        last_q = 32'd0;
        foreach (tbl[i]) begin
            exp_lat(tbl[i].wr, cyc, el);
            do_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, q, lat);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(el));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_data", i), q, tbl[i].exp);
                last_q = tbl[i].exp;
            end
        end

        for (int k = 0; k < 8; k++) ref_w[k] = {pat(33 + 2 * k), pat(32 + 2 * k)};
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 7));
            d = $urandom();
            exp_lat(wr, cyc, el);
            do_op(wr, !wr, 32'(1024 + 4 * (16 + idx)), d, q, lat);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(el));
            if (wr) begin
                ref_w[idx] = d;
                check($sformatf("rnd%0d_hold", n), q, last_q);
            end else begin
                check($sformatf("rnd%0d_data", n), q, ref_w[idx]);
                last_q = ref_w[idx];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule
